// File: rtl/mcs4_pkg.sv
// mcs4_pkg -- shared encodings for the MCS-4 clock generator.
//   SC_A1..SC_X3 : subcycle numbers within an eight-subcycle instruction cycle
//   seg_t        : the four segments of one subcycle (clk1, gap, clk2, gap)
//   step_state_t : run / halt / single-step control states
//   next_seg()   : segment successor, wrapping SEG_GAP2 back to SEG_CLK1
package mcs4_pkg;

  localparam logic [2:0] SC_A1 = 3'd0;
  localparam logic [2:0] SC_A2 = 3'd1;
  localparam logic [2:0] SC_A3 = 3'd2;
  localparam logic [2:0] SC_M1 = 3'd3;
  localparam logic [2:0] SC_M2 = 3'd4;
  localparam logic [2:0] SC_X1 = 3'd5;
  localparam logic [2:0] SC_X2 = 3'd6;
  localparam logic [2:0] SC_X3 = 3'd7;

  typedef enum logic [1:0] {
    SEG_CLK1 = 2'd0,
    SEG_GAP1 = 2'd1,
    SEG_CLK2 = 2'd2,
    SEG_GAP2 = 2'd3
  } seg_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } step_state_t;

  function automatic seg_t next_seg(input seg_t s);
    case (s)
      SEG_CLK1: return SEG_GAP1;
      SEG_GAP1: return SEG_CLK2;
      SEG_CLK2: return SEG_GAP2;
      default:  return SEG_CLK1;
    endcase
  endfunction

endpackage

// File: rtl/mcs4_phase_counter.sv
// mcs4_phase_counter -- tick/segment counter for one subcycle.
// A subcycle is SEG_CLK1 (PHASE_TICKS), SEG_GAP1 (GAP_TICKS), SEG_CLK2
// (PHASE_TICKS), SEG_GAP2 (GAP_TICKS). The counter holds while enable is low.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (-> SEG_CLK1, tick 0)
//   enable         : advance one tick per clock when high
//   seg            : current segment
//   subcycle_done  : high on the enabled tick that wraps SEG_GAP2 -> SEG_CLK1
module mcs4_phase_counter
  import mcs4_pkg::*;
#(
  parameter int PHASE_TICKS = 4,
  parameter int GAP_TICKS   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output seg_t seg,
  output logic subcycle_done
);

  localparam int MAX_TICKS = (PHASE_TICKS > GAP_TICKS) ? PHASE_TICKS : GAP_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  logic [TW-1:0] tick;
  logic [TW-1:0] last_tick;
  logic          seg_done;

  always_comb begin
    last_tick = TW'(GAP_TICKS - 1);
    if (seg == SEG_CLK1 || seg == SEG_CLK2) last_tick = TW'(PHASE_TICKS - 1);
  end

  assign seg_done      = (tick == last_tick);
  assign subcycle_done = enable && seg_done && (seg == SEG_GAP2);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg  <= SEG_CLK1;
      tick <= '0;
    end else if (enable) begin
      if (seg_done) begin
        seg  <= next_seg(seg);
        tick <= '0;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcs4_clkgen.sv
// mcs4_clkgen -- two-phase clock, SYNC and power-on-clear generator.
// Outputs are registered decodes of the counter state one tick behind it, so
// the first edge after reset presents X3/S0 (clk1_pad=1, sync_pad=1).
// Ports:
//   sysclk    : system clock
//   poc       : asynchronous active-high reset
//   run       : free-run enable (step build only)
//   step_req  : single-step request, rising-edge detected (step build only)
//   clk1_pad  : phase-1 clock        clk2_pad : phase-2 clock
//   sync_pad  : high throughout X3   poc_pad  : stretched power-on clear
//   subcycle  : current subcycle (A1=0 .. X3=7)
//   step_ack  : one-sysclk pulse on the edge that ends a single step
// Build option: define MCS4_CLKGEN_STEP_EN to enable run/halt/single-step
// control; otherwise the generator free-runs and step_ack is tied low.
module mcs4_clkgen
  import mcs4_pkg::*;
#(
  parameter int PHASE_TICKS = 4,
  parameter int GAP_TICKS   = 1,
  parameter int POC_CYCLES  = 4
) (
  input  logic       sysclk,
  input  logic       poc,
  input  logic       run,
  input  logic       step_req,
  output logic       clk1_pad,
  output logic       clk2_pad,
  output logic       sync_pad,
  output logic       poc_pad,
  output logic [2:0] subcycle,
  output logic       step_ack
);

  localparam int PW = $clog2(POC_CYCLES + 1);

  seg_t          seg;
  logic          subcycle_done;
  logic          enable;
  logic [2:0]    sc;
  logic          cycle_start;  // counter sits at A1/S0/tick0
  logic [PW-1:0] poc_cnt;

  mcs4_phase_counter #(
    .PHASE_TICKS(PHASE_TICKS),
    .GAP_TICKS  (GAP_TICKS)
  ) u_phase (
    .clk          (sysclk),
    .rst          (poc),
    .enable       (enable),
    .seg          (seg),
    .subcycle_done(subcycle_done)
  );

  // Subcycle counter and instruction-cycle boundary flag. cycle_start stays
  // set while halted, since a halt always parks the counter at A1/S0/tick0.
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      sc          <= SC_X3;
      cycle_start <= 1'b0;
    end else if (enable) begin
      if (subcycle_done) sc <= (sc == SC_X3) ? SC_A1 : sc + 3'd1;
      cycle_start <= subcycle_done && (sc == SC_X3);
    end
  end

  // POC stretcher: counts A1 entries; the entry after POC_CYCLES complete
  // cycles releases poc_pad. The partial X3 after reset never reaches here.
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      poc_cnt <= '0;
      poc_pad <= 1'b1;
    end else if (enable && cycle_start) begin
      if (poc_cnt == PW'(POC_CYCLES)) poc_pad <= 1'b0;
      else                            poc_cnt <= poc_cnt + 1'b1;
    end
  end

  // Output registers. A disabled (halted) edge forces clocks and sync low.
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      clk1_pad <= 1'b0;
      clk2_pad <= 1'b0;
      sync_pad <= 1'b0;
      subcycle <= SC_X3;
    end else begin
      clk1_pad <= enable && (seg == SEG_CLK1);
      clk2_pad <= enable && (seg == SEG_CLK2);
      sync_pad <= enable && (sc == SC_X3);
      subcycle <= sc;
    end
  end

`ifdef MCS4_CLKGEN_STEP_EN
  step_state_t state, state_next;
  logic        step_req_q;
  logic        step_rise;
  logic        ack_next;

  assign step_rise = step_req && !step_req_q;

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state      <= ST_RUN;
      step_req_q <= 1'b0;
      step_ack   <= 1'b0;
    end else begin
      state      <= state_next;
      step_req_q <= step_req;
      step_ack   <= ack_next;
    end
  end

  // Halts are only taken at the X3->A1 boundary; step edges are only
  // honoured from HALT, so edges while running or stepping are dropped.
  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    enable     = 1'b1;
    ack_next   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (cycle_start && !run) begin
          state_next = ST_HALT;
          enable     = 1'b0;
        end
      end
      ST_HALT: begin
        enable = 1'b0;
        if (run) begin
          state_next = ST_RUN;
          enable     = 1'b1;
        end else if (step_rise) begin
          state_next = ST_STEP;
          enable     = 1'b1;
        end
      end
      ST_STEP: begin
        if (cycle_start) begin
          state_next = ST_HALT;
          enable     = 1'b0;
          ack_next   = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end
`else
  logic unused_inputs;

  assign enable        = 1'b1;
  assign step_ack      = 1'b0;
  assign unused_inputs = run ^ step_req;
`endif

endmodule

// File: doc/mcs4_clkgen.md
# mcs4_clkgen

Two-phase clock, SYNC and power-on-clear generator for the MCS-4 emulation. It derives non-overlapping `clk1_pad`/`clk2_pad` from `sysclk` and asserts `sync_pad` during X3 to mark the start of each eight-subcycle instruction cycle. It also holds a stretched `poc_pad` so that downstream i4001/i4002/4004 instances see a clean power-on clear. It sits directly upstream of every i4001, feeding its clock, sync and poc pad inputs, and those chips' timing recovery logic.

## Interface
- `PHASE_TICKS`, 4: sysclk cycles each clock phase is high; must be ≥1.
- `GAP_TICKS`, 1: sysclk cycles of non-overlap after each phase; must be ≥1.
- `POC_CYCLES`, 4: complete instruction cycles that `poc_pad` is held after reset release; must be ≥1.
- `sysclk` input 1: the single system clock.
- `poc` input 1: asynchronous, active-high reset.
- `run` input 1: free-run enable. Used only with the step feature.
- `step_req` input 1: single-step request. Rising-edge detected.
- `clk1_pad` output 1: phase-1 clock.
- `clk2_pad` output 1: phase-2 clock.
- `sync_pad` output 1: high throughout subcycle X3.
- `poc_pad` output 1: stretched power-on clear.
- `subcycle` output 3: current subcycle. A1=0, A2, A3, M1, M2, X1, X2, X3=7.
- `step_ack` output 1: one-sysclk pulse when a step completes.

## Operation
- Each subcycle has four segments: S0 (clk1 high, PHASE_TICKS), S1 (gap, GAP_TICKS), S2 (clk2 high, PHASE_TICKS), S3 (gap, GAP_TICKS). Subcycle length is 2·(PHASE_TICKS+GAP_TICKS) sysclk.
- When S3 wraps, `subcycle` increments modulo 8.
- `sync_pad` = (subcycle==X3), registered, aligned with S0 start of X3.
- Reset values: counters at X3/S0/tick0; `clk1_pad`=0, `clk2_pad`=0, `sync_pad`=0, `poc_pad`=1, `subcycle`=7, `step_ack`=0.
- POC counter: increments on each entry into A1 and saturates at POC_CYCLES. `poc_pad` falls on the edge that enters A1 once POC_CYCLES complete A1..X3 cycles have elapsed. The partial X3 after reset does not count.
- `clk1_pad` and `clk2_pad` are never both high. Each transition between them has ≥GAP_TICKS sysclk of both low.
- Reset asserted mid-cycle: all outputs return to their reset values immediately (async), and the POC counter clears.

## Timing
- All outputs are registered. The first edge after reset release presents X3/S0: `clk1_pad`=1, `sync_pad`=1.
- Defaults: clk1 is high 4 sysclk and low 6. `clk2_pad` rises 5 sysclk after `clk1_pad` rises. A subcycle is 10 sysclk; an instruction cycle is 80 sysclk.
- `subcycle` changes on the same edge that raises `clk1_pad` for the new subcycle.

## Configuration
- `MCS4_CLKGEN_STEP_EN` defined:
  - `run`=0 halts the generator at the X3→A1 boundary, with both clocks low, `sync_pad`=0, and the POC counter frozen. `subcycle` reads 0.
  - `run` dropping mid-cycle completes the current cycle before halting.
  - While halted, a `step_req` rising edge runs exactly one A1..X3 cycle, then halts again. `step_ack` pulses for one sysclk on the halting edge.
  - `step_req` edges while running, or while a step is in progress, are ignored. A held-high `step_req` yields only one step.
  - `run` rising while halted resumes at A1 on the next edge.
- Not defined: the generator free-runs; `run` and `step_req` are ignored; `step_ack` is tied 0.

## Structure
- `mcs4_pkg`:
  - subcycle localparams `SC_A1`..`SC_X3`
  - segment encoding `SEG_CLK1`, `SEG_GAP1`, `SEG_CLK2`, `SEG_GAP2`
- Sub-module `mcs4_phase_counter`: tick/segment counter taking PHASE_TICKS and GAP_TICKS. It outputs the segment and a `subcycle_done` strobe, plus an `enable` input used for halting.
- The top level holds the subcycle counter, the POC stretcher, the step FSM (RUN, HALT, STEP) and the output registers.

## Test plan
- Defaults, reset released → first edge: clk1=1, sync=1, subcycle=7. Then clk1 high 4 / low 6 repeating. clk2 rises 5 sysclk after each clk1 rise. Both clocks are never high together.
- Free-run 1000 sysclk → `sync_pad` high exactly 10 of every 80 sysclk. `subcycle` sequence is 7,0,1..7.
- Reset release → `poc_pad`=1 through edge 330 and 0 from edge 331. It stays 0 thereafter.
- Reset asserted at subcycle M2/S2 → clk2=0, poc_pad=1 and subcycle=7 immediately, without waiting for a clock edge.
- Macro on, `run`=0 at subcycle X1 → completes X1..X3, then halts with clocks low. `step_req` pulse → exactly 80 sysclk of activity, then `step_ack`=1 for one sysclk, then halted.
- Macro off, `run`=0 with `step_req` toggling → unaffected free-run, `step_ack`=0.
